// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder processes the operands LSB-first,
// one bit per clock, with its carry-out fed back through a carry flip-flop.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_sum, fa_cout;
   logic             load, step, last;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_res1
         assign res_next = fa_sum;
      end else begin : g_resn
         assign res_next = {fa_sum, res_sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = ADD;
            end
         end
         ADD: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == LAST) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = ADD;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Published sum/cout only move on the completion edge; partials stay internal.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
      end else if (load) begin
         a_sr   <= a;
         b_sr   <= b;
         carry  <= cin;
         res_sr <= '0;
         cnt    <= '0;
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         carry  <= fa_cout;
         res_sr <= res_next;
         cnt    <= cnt + CW'(1);
         if (last) begin
            sum  <= res_next;
            cout <= fa_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes a + b + cin results,
// a done-driven monitor pops and compares them along with completion latency.

module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int           compared   = 0;
   int           mismatched = 0;
   int           cyc        = 0;
   int           lastDoneCyc = 0;
   int           prevDoneCyc = 0;
   logic [W:0]   expQ[$];
   int           accQ[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && done === 1'b1) begin
         prevDoneCyc = lastDoneCyc;
         lastDoneCyc = cyc;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 64'd1, 64'd0);
         end else begin
            logic [W:0] e;
            int acc;
            e   = expQ.pop_front();
            acc = accQ.pop_front();
            checkOutput("sum", 64'(sum), 64'(e[W-1:0]));
            checkOutput("cout", 64'(cout), 64'(e[W]));
            checkOutput("latency", 64'(cyc - acc), 64'(W));
         end
      end
   end

   task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input bit push);
      int guard = 0;
      @(negedge clk);
      while (busy !== 1'b0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) checkOutput("idle_timeout", 64'd1, 64'd0);
      a = ta; b = tb_; cin = tc; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         expQ.push_back(refAdd(ta, tb_, tc));
         accQ.push_back(cyc);
      end
   endtask

   task automatic waitIdle();
      int guard = 0;
      while (expQ.size() != 0 && guard < 20 * W) begin
         @(negedge clk);
         guard++;
      end
      if (expQ.size() != 0) begin
         checkOutput("done_timeout", 64'(expQ.size()), 64'd0);
         expQ.delete();
         accQ.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("reset_busy", 64'(busy), 64'd0);
         checkOutput("reset_done", 64'(done), 64'd0);
         checkOutput("reset_sum", 64'(sum), 64'd0);
         checkOutput("reset_cout", 64'(cout), 64'd0);
      end

      applyStimulus(8'h35, 8'h4A, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("busy_in_add", 64'(busy), 64'd1);
      waitIdle();
      applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1);
      waitIdle();
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
      waitIdle();

      // Operands scrambled and a stray start raised while the add is running.
      applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         start = (i == 2);
      end
      @(negedge clk) start = 1'b0;
      waitIdle();
      repeat (W + 3) @(negedge clk);

      // Back-to-back with start held high across the completion cycle.
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      expQ.push_back(refAdd(8'h01, 8'h01, 1'b0));
      accQ.push_back(cyc);
      a = 8'h80; b = 8'h80;
      begin
         int guard = 0;
         @(negedge clk);
         while (done !== 1'b1 && guard < 4 * W) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 4 * W) checkOutput("b2b_timeout", 64'd1, 64'd0);
      end
      @(posedge clk);
      #1;
      expQ.push_back(refAdd(8'h80, 8'h80, 1'b0));
      accQ.push_back(cyc);
      start = 1'b0;
      waitIdle();
      checkOutput("b2b_gap", 64'(lastDoneCyc - prevDoneCyc), 64'(W + 1));

      // Reset in the fourth ADD cycle discards the partial result.
      applyStimulus(8'h55, 8'h66, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      checkOutput("midrst_sum", 64'(sum), 64'd0);
      checkOutput("midrst_cout", 64'(cout), 64'd0);
      repeat (W + 2) @(negedge clk);
      applyStimulus(8'h0F, 8'h01, 1'b0, 1'b1);
      waitIdle();

      for (int n = 0; n < 30; n++) begin
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
         if ($urandom_range(0, 1) == 1) waitIdle();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      waitIdle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
